// File: rtl/risc0_host_port.sv
`default_nettype none
// ============================================================================
// Module  : risc0_host_port
// Purpose : Host-side bridge of the RISC0 executor. It routes host accesses to
//           a memory bus or to a local control/status register window.
// Revision: 1.0
// ============================================================================
module risc0_host_port #(
  parameter logic [31:0] REG_BASE = 32'hF000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_data_in,
  input  logic        host_we,
  input  logic        host_re,
  output logic [31:0] host_data_out,
  output logic        host_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        start_execution,
  output logic [31:0] segment_threshold,
  output logic [31:0] max_cycles,
  input  logic        execution_done,
  input  logic        execution_error,
  input  logic [63:0] user_cycles,
  input  logic [63:0] total_cycles,
  input  logic [31:0] current_pc
);

  localparam logic [31:0] c_tmo_last  = 32'(TIMEOUT - 1);
  localparam logic [31:0] c_off_ctrl  = 32'h00;
  localparam logic [31:0] c_off_seg   = 32'h04;
  localparam logic [31:0] c_off_max   = 32'h08;
  localparam logic [31:0] c_off_pc    = 32'h0C;
  localparam logic [31:0] c_off_ulo   = 32'h10;
  localparam logic [31:0] c_off_uhi   = 32'h14;
  localparam logic [31:0] c_off_tlo   = 32'h18;
  localparam logic [31:0] c_off_thi   = 32'h1C;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_REQ  = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata, r_data_out;
  logic [31:0] r_seg, r_max, r_user_sh, r_total_sh, r_cnt;
  logic        r_we, r_is_reg, r_ready, r_running, r_bus_err;
  logic [31:0] w_off, w_reg_rdata;
  logic        w_tmo_hit, w_start, w_strobe;

  assign w_strobe  = host_we | host_re;
  assign w_off     = r_addr - REG_BASE;
  // A timeout only fires when the bus has not made progress in that cycle.
  assign w_tmo_hit = (r_cnt >= c_tmo_last) &&
                     (((r_state == S_MEM_REQ) && !mem_gnt) ||
                      ((r_state == S_MEM_WAIT) && !mem_rvalid));
  assign w_start   = (r_state == S_RESP) && r_we && r_is_reg && (w_off == c_off_ctrl) &&
                     r_wdata[0] && !r_running && !execution_done && !execution_error;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_strobe) w_next = (host_addr >= REG_BASE) ? S_RESP : S_MEM_REQ;
      S_MEM_REQ:  if (mem_gnt) w_next = r_we ? S_RESP : S_MEM_WAIT;
                  else if (w_tmo_hit) w_next = S_RESP;
      S_MEM_WAIT: if (mem_rvalid || w_tmo_hit) w_next = S_RESP;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_off)
      c_off_ctrl: w_reg_rdata = {29'b0, r_bus_err, execution_error, execution_done};
      c_off_seg:  w_reg_rdata = r_seg;
      c_off_max:  w_reg_rdata = r_max;
      c_off_pc:   w_reg_rdata = current_pc;
      c_off_ulo:  w_reg_rdata = user_cycles[31:0];
      c_off_uhi:  w_reg_rdata = r_user_sh;
      c_off_tlo:  w_reg_rdata = total_cycles[31:0];
      c_off_thi:  w_reg_rdata = r_total_sh;
      default:    w_reg_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_data_out <= 32'h0;
      r_seg      <= 32'd1000;
      r_max      <= 32'd10000;
      r_user_sh  <= 32'h0;
      r_total_sh <= 32'h0;
      r_cnt      <= 32'h0;
      r_we       <= 1'b0;
      r_is_reg   <= 1'b0;
      r_ready    <= 1'b0;
      r_running  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (r_state == S_RESP);

      if (r_state == S_IDLE) begin
        r_cnt <= 32'h0;
        if (w_strobe) begin
          r_addr   <= host_addr;
          r_wdata  <= host_data_in;
          r_we     <= host_we;
          r_is_reg <= (host_addr >= REG_BASE);
        end
      end else if (r_state == S_MEM_REQ || r_state == S_MEM_WAIT) begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (r_state == S_MEM_WAIT && mem_rvalid) r_rdata <= mem_rdata;
      if (w_tmo_hit) begin
        r_rdata   <= 32'hFFFF_FFFF;
        r_bus_err <= 1'b1;
      end

      if (r_state == S_RESP && !r_we) begin
        r_data_out <= r_is_reg ? w_reg_rdata : r_rdata;
        if (r_is_reg && w_off == c_off_ulo) r_user_sh  <= user_cycles[63:32];
        if (r_is_reg && w_off == c_off_tlo) r_total_sh <= total_cycles[63:32];
      end

      if (r_state == S_RESP && r_we && r_is_reg) begin
        case (w_off)
          c_off_ctrl: if (r_wdata[1]) r_bus_err <= 1'b0;
          c_off_seg:  r_seg <= r_wdata;
          c_off_max:  r_max <= r_wdata;
          default:    ;
        endcase
      end

      // A finishing executor overrides a simultaneous start request.
      if (execution_done || execution_error) r_running <= 1'b0;
      else if (w_start)                      r_running <= 1'b1;
    end
  end

  assign host_data_out     = r_data_out;
  assign host_ready        = r_ready;
  assign mem_req           = (r_state == S_MEM_REQ);
  assign mem_we            = (r_state == S_MEM_REQ) && r_we;
  assign mem_addr          = r_addr;
  assign mem_wdata         = r_wdata;
  assign start_execution   = w_start;
  assign segment_threshold = r_seg;
  assign max_cycles        = r_max;

endmodule
`default_nettype wire

// File: tb/tb_risc0_host_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc0_host_port
// Purpose : Directed self-checking bench for risc0_host_port.
// Revision: 1.0
// ============================================================================
module tb_risc0_host_port;

  localparam logic [31:0] c_rb = 32'hF000_0000;

  logic        clk, rst;
  logic [31:0] host_addr, host_data_in, host_data_out;
  logic        host_we, host_re, host_ready;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        start_execution, execution_done, execution_error;
  logic [31:0] segment_threshold, max_cycles, current_pc;
  logic [63:0] user_cycles, total_cycles;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulses = 0;
  logic        cap_valid, cap_stable, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  int          cap_reqs;

  risc0_host_port #(.REG_BASE(32'hF000_0000), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .host_addr(host_addr), .host_data_in(host_data_in),
    .host_we(host_we), .host_re(host_re),
    .host_data_out(host_data_out), .host_ready(host_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .start_execution(start_execution),
    .segment_threshold(segment_threshold), .max_cycles(max_cycles),
    .execution_done(execution_done), .execution_error(execution_error),
    .user_cycles(user_cycles), .total_cycles(total_cycles), .current_pc(current_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (start_execution === 1'b1) n_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one host transaction and plays the memory side; lat counts edges
  // from the sampling edge up to the edge that raises host_ready.
  task automatic host_txn(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input logic gen, input int gdly,
                          input int rvdly, input logic [31:0] rd,
                          output logic [31:0] dout, output int lat);
    int   req_n, wn;
    logic granted;
    @(negedge clk);
    host_addr = a; host_data_in = wd; host_we = we; host_re = re;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    lat = 0; req_n = 0; wn = 0; granted = 1'b0;
    cap_valid = 1'b0; cap_stable = 1'b1;
    while (1) begin
      @(posedge clk);
      if (mem_gnt) granted = 1'b1;
      #1; lat++;
      if (host_ready === 1'b1 || lat >= 600) break;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (mem_req) begin
        req_n++;
        if (!cap_valid) begin
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_valid = 1'b1;
        end else if (mem_we !== cap_we || mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
          cap_stable = 1'b0;
        end
        if (gen && req_n > gdly) mem_gnt = 1'b1;
      end
      if (granted) begin
        wn++;
        if (wn == rvdly) begin mem_rvalid = 1'b1; mem_rdata = rd; end
      end
    end
    host_we = 1'b0; host_re = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    dout = host_data_out;
    cap_reqs = req_n;
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, output int lat);
    logic [31:0] dummy;
    host_txn(1'b1, 1'b0, a, d, 1'b0, 0, 0, 32'h0, dummy, lat);
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output int lat);
    host_txn(1'b0, 1'b1, a, 32'h0, 1'b0, 0, 0, 32'h0, d, lat);
  endtask

  initial begin
    logic [31:0] d;
    int          lat, p0;
    logic        seen;

    rst = 1'b1; host_addr = 0; host_data_in = 0; host_we = 0; host_re = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    execution_done = 0; execution_error = 0;
    user_cycles = 0; total_cycles = 0; current_pc = 32'h0000_1234;
    cap_we = 0; cap_addr = 0; cap_wdata = 0; cap_valid = 0; cap_stable = 1; cap_reqs = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", host_ready, 0);
    check("rst_dout", host_data_out, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_start", start_execution, 0);
    check("rst_seg", segment_threshold, 1000);
    check("rst_max", max_cycles, 10000);
    @(negedge clk) rst = 1'b0;

    reg_rd(c_rb + 32'h4, d, lat);
    check("seg_rd_reset", d, 1000);
    check("reg_rd_latency", lat, 2);
    reg_wr(c_rb + 32'h4, 5, lat);
    check("reg_wr_latency", lat, 2);
    reg_rd(c_rb + 32'h4, d, lat);
    check("seg_rd_5", d, 5);
    reg_wr(c_rb + 32'h8, 77, lat);
    reg_rd(c_rb + 32'h8, d, lat);
    check("max_rd", d, 77);
    check("max_out", max_cycles, 77);
    check("seg_out", segment_threshold, 5);

    // Memory write, immediate grant.
    host_txn(1'b1, 1'b0, 32'h0, 32'h0010_0093, 1'b1, 0, 0, 32'h0, d, lat);
    check("mwr_we", cap_we, 1);
    check("mwr_addr", cap_addr, 32'h0);
    check("mwr_wdata", cap_wdata, 32'h0010_0093);
    check("mwr_latency", lat, 3);
    check("mwr_dout_held", d, 77);
    @(posedge clk); #1;
    check("mwr_ready_pulse", host_ready, 0);

    // Memory read, rvalid in the third cycle after grant.
    host_txn(1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 0, 3, 32'h0020_0113, d, lat);
    check("mrd_data", d, 32'h0020_0113);
    check("mrd_we", cap_we, 0);
    check("mrd_addr", cap_addr, 32'h4);
    check("mrd_latency", lat, 6);

    // Delayed grant: request held stable for four cycles.
    host_txn(1'b1, 1'b0, 32'h40, 32'hCAFE_0001, 1'b1, 3, 0, 32'h0, d, lat);
    check("mwr_stable", cap_stable, 1);
    check("mwr_req_cycles", cap_reqs, 4);
    check("mwr_dly_latency", lat, 6);

    // Timeout with grant never given.
    host_txn(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 0, 0, 32'h0, d, lat);
    check("tmo_data", d, 32'hFFFF_FFFF);
    check("tmo_latency", lat, 257);
    reg_rd(c_rb, d, lat);
    check("ctrl_bus_err", d, 32'h4);
    reg_wr(c_rb, 32'h2, lat);
    reg_rd(c_rb, d, lat);
    check("ctrl_bus_err_clr", d, 32'h0);

    // Start pulses and running interlock.
    p0 = n_pulses;
    reg_wr(c_rb, 32'h1, lat);
    check("start_first", n_pulses - p0, 1);
    reg_wr(c_rb, 32'h1, lat);
    check("start_while_running", n_pulses - p0, 1);
    @(negedge clk) execution_done = 1'b1;
    @(negedge clk) execution_done = 1'b0;
    reg_wr(c_rb, 32'h1, lat);
    check("start_after_done", n_pulses - p0, 2);
    @(negedge clk) execution_done = 1'b1;
    @(negedge clk);
    reg_wr(c_rb, 32'h1, lat);
    check("start_vs_done", n_pulses - p0, 2);
    execution_error = 1'b1;
    reg_rd(c_rb, d, lat);
    check("ctrl_status", d, 32'h3);
    execution_done = 1'b0; execution_error = 1'b0;
    reg_wr(c_rb, 32'h1, lat);
    check("start_after_clear", n_pulses - p0, 3);

    // Snapshot counters, PC, unmapped space.
    user_cycles = 64'h1_FFFF_FFFF;
    reg_rd(c_rb + 32'h10, d, lat);
    check("user_lo", d, 32'hFFFF_FFFF);
    user_cycles = 64'h2_0000_0000;
    reg_rd(c_rb + 32'h14, d, lat);
    check("user_hi", d, 32'h1);
    total_cycles = 64'h3_0000_0005;
    reg_rd(c_rb + 32'h18, d, lat);
    check("total_lo", d, 32'h5);
    total_cycles = 64'h9_0000_0000;
    reg_rd(c_rb + 32'h1C, d, lat);
    check("total_hi", d, 32'h3);
    reg_wr(c_rb + 32'hC, 32'hDEAD_BEEF, lat);
    reg_rd(c_rb + 32'hC, d, lat);
    check("pc_readonly", d, 32'h0000_1234);
    reg_rd(c_rb + 32'h20, d, lat);
    check("unmapped_rd", d, 32'h0);
    check("unmapped_rd_lat", lat, 2);
    reg_wr(c_rb + 32'h20, 32'h1, lat);
    check("unmapped_wr_lat", lat, 2);

    // Both strobes: the write wins.
    host_txn(1'b1, 1'b1, c_rb + 32'h4, 32'h9, 1'b0, 0, 0, 32'h0, d, lat);
    reg_rd(c_rb + 32'h4, d, lat);
    check("write_wins", d, 32'h9);

    // Reset in the middle of a memory request.
    @(negedge clk);
    host_addr = 32'h200; host_re = 1'b1; mem_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_req_before", mem_req, 1);
    @(negedge clk);
    rst = 1'b1; host_re = 1'b0;
    @(posedge clk); #1;
    check("abort_req_dropped", mem_req, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (host_ready === 1'b1) seen = 1'b1;
    end
    check("abort_no_ready", seen, 0);
    check("abort_seg_reset", segment_threshold, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
